pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register, the successor to the fixed-field stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a WIDTH-bit packed stage bundle with a valid/ready handshake instead of a bare enable. It supports flush-to-bubble with a programmable bubble pattern, and an optional two-entry skid buffer that breaks the combinational ready path between stages. One instance sits between each pair of pipeline stages; hazard/forwarding logic drives `flush` and `out_ready`.

---
 rtl/cpu_types_pkg.sv | 72 +++++++
 rtl/pipe_skid_buf.sv | 45 ++++
 rtl/pipe_stage_reg.sv | 116 +++++++++++
 tb/tb_pipe_stage_reg.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: pipeline register state and per-stage packed bundles with their NOP bubbles.
// The bubble constants are typed as their bundle, so their width always equals $bits(bundle).
package cpu_types_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_t;

    typedef enum logic [1:0] {
        PC_NEXT   = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_JR     = 2'd3
    } pc_select_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] npc;
    } ifid_t;

    typedef struct packed {
        pc_select_t  pc_select;
        logic        wen;
        logic        dren;
        logic        dwen;
        logic        halt;
        logic [4:0]  wsel;
        logic [3:0]  alu_op;
        logic [31:0] rdat1;
        logic [31:0] rdat2;
        logic [31:0] imm;
        logic [31:0] npc;
    } idex_t;

    typedef struct packed {
        logic        wen;
        logic        dren;
        logic        dwen;
        logic        halt;
        logic [4:0]  wsel;
        logic [31:0] alu_out;
        logic [31:0] store_data;
        logic [31:0] npc;
    } exmem_t;

    typedef struct packed {
        logic        wen;
        logic        halt;
        logic [4:0]  wsel;
        logic [31:0] wdat;
        logic [31:0] npc;
    } memwb_t;

    localparam ifid_t IFID_BUBBLE = '{instr: 32'h0000_0000, npc: 32'h0000_0000};

    localparam idex_t IDEX_BUBBLE = '{
        pc_select: PC_NEXT, wen: 1'b0, dren: 1'b0, dwen: 1'b0, halt: 1'b0,
        wsel: 5'd0, alu_op: 4'd0, rdat1: 32'd0, rdat2: 32'd0, imm: 32'd0, npc: 32'd0
    };

    localparam exmem_t EXMEM_BUBBLE = '{
        wen: 1'b0, dren: 1'b0, dwen: 1'b0, halt: 1'b0,
        wsel: 5'd0, alu_out: 32'd0, store_data: 32'd0, npc: 32'd0
    };

    localparam memwb_t MEMWB_BUBBLE = '{
        wen: 1'b0, halt: 1'b0, wsel: 5'd0, wdat: 32'd0, npc: 32'd0
    };

endpackage

// File: rtl/pipe_skid_buf.sv
// Second entry of a skid-enabled pipeline register: holds the bundle caught during a stall
// and produces the registered upstream ready. Only instantiated when PIPE_SKID_EN is defined.
module pipe_skid_buf #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             flush,
    input  logic             load,
    input  logic             unload,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data,
    output logic             ready
);

    logic             valid_q;
    logic             valid_d;
    logic             ready_q;
    logic [WIDTH-1:0] data_q;

    always_comb begin
        valid_d = valid_q;
        if (flush)       valid_d = 1'b0;
        else if (load)   valid_d = 1'b1;
        else if (unload) valid_d = 1'b0;
    end

    // Ready is low during reset and tracks "skid entry free" from the first edge after it.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            valid_q <= 1'b0;
            ready_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ready_q <= !valid_d;
            if (flush)     data_q <= '0;
            else if (load) data_q <= data_in;
        end
    end

    assign data  = data_q;
    assign ready = ready_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush-to-BUBBLE and,
// when PIPE_SKID_EN is defined, a second skid entry with a registered in_ready.
module pipe_stage_reg
    import cpu_types_pkg::*;
#(
    parameter int unsigned      WIDTH  = 32,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    pipe_state_t      state_q;
    pipe_state_t      state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_d;
    logic             in_fire;

`ifdef PIPE_SKID_EN
    logic             skid_load;
    logic             skid_unload;
    logic             skid_ready;
    logic [WIDTH-1:0] skid_data;

    pipe_skid_buf #(.WIDTH(WIDTH)) u_skid (
        .CLK     (CLK),
        .nRST    (nRST),
        .flush   (flush),
        .load    (skid_load),
        .unload  (skid_unload),
        .data_in (in_data),
        .data    (skid_data),
        .ready   (skid_ready)
    );
`endif

    assign in_fire = in_valid & in_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= EMPTY;
            main_q  <= BUBBLE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        main_d      = main_q;
`ifdef PIPE_SKID_EN
        skid_load   = 1'b0;
        skid_unload = 1'b0;
`endif
        if (flush) begin
            state_d = EMPTY;
            main_d  = BUBBLE;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = FULL;
                        main_d  = in_data;
                    end
                end
                FULL: begin
                    if (in_fire && out_ready) begin
                        main_d = in_data;
                    end else if (in_fire) begin
`ifdef PIPE_SKID_EN
                        state_d   = SKID;
                        skid_load = 1'b1;
`endif
                    end else if (out_ready) begin
                        state_d = EMPTY;
                        main_d  = BUBBLE;
                    end
                end
`ifdef PIPE_SKID_EN
                SKID: begin
                    if (out_ready) begin
                        state_d     = FULL;
                        main_d      = skid_data;
                        skid_unload = 1'b1;
                    end
                end
`endif
                default: begin
                    state_d = EMPTY;
                    main_d  = BUBBLE;
                end
            endcase
        end
    end

    always_comb begin
        out_valid = (state_q != EMPTY);
        out_data  = main_q;
`ifdef PIPE_SKID_EN
        in_ready  = skid_ready;
`else
        in_ready  = !out_valid | out_ready;
`endif
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg with a non-zero BUBBLE pattern;
// stall expectations follow whichever build (PIPE_SKID_EN or not) is compiled.
module tb_pipe_stage_reg;

    localparam logic [31:0] BUB = 32'h0000_0004;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int tests  = 0;
    int failed = 0;

    pipe_stage_reg #(.WIDTH(32), .BUBBLE(BUB)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        nRST      = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hDEAD_BEEF;
        out_ready = 1'b1;

        // Reset held for two edges with a valid bundle offered
        step();
        step();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, BUB);
`ifdef PIPE_SKID_EN
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
`endif
        nRST     = 1'b1;
        in_valid = 1'b0;
        step();
        check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("post_rst_out_data", out_data, BUB);

        // Streaming: 0x10..0x17, one per cycle, each visible one cycle after entry
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h10 + 32'(i);
            step();
            check("stream_valid", {31'd0, out_valid}, 32'd1);
            check("stream_data", out_data, 32'h10 + 32'(i));
            check("stream_in_ready", {31'd0, in_ready}, 32'd1);
        end
        in_valid = 1'b0;
        step();
        check("drain_valid", {31'd0, out_valid}, 32'd0);
        check("drain_bubble", out_data, BUB);

        // Flush of a full stage drops the concurrent input; flush held two cycles
        in_valid = 1'b1;
        in_data  = 32'h55;
        step();
        check("pre_flush_data", out_data, 32'h55);
        flush     = 1'b1;
        in_data   = 32'h66;
        out_ready = 1'b0;
        step();
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        check("flush_bubble", out_data, BUB);
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("flush_hold_valid", {31'd0, out_valid}, 32'd0);
        check("flush_hold_bubble", out_data, BUB);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("after_flush_valid", {31'd0, out_valid}, 32'd0);

`ifdef PIPE_SKID_EN
        // Stall: A0, A1, A2 with downstream stalled, then release
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA0;
        step();
        check("stall_a0", out_data, 32'hA0);
        check("stall_rdy0", {31'd0, in_ready}, 32'd1);
        in_data = 32'hA1;
        step();
        check("stall_a0_hold", out_data, 32'hA0);
        check("stall_rdy_fall", {31'd0, in_ready}, 32'd0);
        in_data = 32'hA2;
        step();
        check("stall_a0_hold2", out_data, 32'hA0);
        check("stall_rdy_low", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        step();
        check("release_a1", out_data, 32'hA1);
        check("release_rdy", {31'd0, in_ready}, 32'd1);
        step();
        check("release_a2", out_data, 32'hA2);
        in_valid = 1'b0;
        step();
        check("release_empty", {31'd0, out_valid}, 32'd0);

        // Flush while in SKID holding B0/B1, with B2 offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hB0;
        step();
        in_data = 32'hB1;
        step();
        check("skid_b_rdy", {31'd0, in_ready}, 32'd0);
        flush   = 1'b1;
        in_data = 32'hB2;
        step();
        check("skid_flush_valid", {31'd0, out_valid}, 32'd0);
        check("skid_flush_bubble", out_data, BUB);
        check("skid_flush_rdy", {31'd0, in_ready}, 32'd1);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("skid_flush_stays_empty", {31'd0, out_valid}, 32'd0);
        check("skid_flush_no_b", out_data, BUB);
`else
        // Stall: stage holds C0 and refuses C1 until downstream is ready
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hC0;
        step();
        check("stall_c0", out_data, 32'hC0);
        check("stall_rdy_low", {31'd0, in_ready}, 32'd0);
        in_data = 32'hC1;
        step();
        check("stall_c0_hold", out_data, 32'hC0);
        out_ready = 1'b1;
        #1;
        check("stall_rdy_comb", {31'd0, in_ready}, 32'd1);
        step();
        check("release_c1", out_data, 32'hC1);
        in_valid = 1'b0;
        step();
        check("release_empty", {31'd0, out_valid}, 32'd0);
        check("release_bubble", out_data, BUB);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
